// File: rtl/leiwand_rv32_wb_uart_tx_if.sv
// leiwand_rv32_wb_uart_tx_if: Wishbone responder bus bundle for the UART transmitter
interface leiwand_rv32_wb_uart_tx_if #(
   parameter int MEM_WIDTH = 32,
   parameter int ADDR_WIDTH = 2
);
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [MEM_WIDTH-1:0] wb_data_in;
   logic [MEM_WIDTH-1:0] wb_data_out;
   logic wb_we;
   logic wb_stb;
   logic wb_ack;
   logic wb_cyc;
   logic wb_stall;
   modport master (
      output wb_addr, wb_data_in, wb_we, wb_stb, wb_cyc,
      input  wb_data_out, wb_ack, wb_stall
   );
   modport slave (
      input  wb_addr, wb_data_in, wb_we, wb_stb, wb_cyc,
      output wb_data_out, wb_ack, wb_stall
   );
endinterface

// File: rtl/leiwand_rv32_wb_uart_tx.sv
// leiwand_rv32_wb_uart_tx: Wishbone UART transmitter (8N1) with TX FIFO and programmable baud divisor
module leiwand_rv32_wb_uart_tx #(
   parameter int MEM_WIDTH = 32,
   parameter int ADDR_WIDTH = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int BAUD_DIV_RESET = 16
) (
   input  logic clk,
   input  logic reset,
   leiwand_rv32_wb_uart_tx_if.slave wb,
   output logic uart_tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_n;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, count;
   logic [15:0] baud_div, div, div_n, cnt, cnt_n;
   logic [7:0] shreg, shreg_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic full, empty, accept, push, pop, last, tx_n;
   logic [MEM_WIDTH-1:0] rdata;
   assign count = wr_ptr - rd_ptr;
   assign empty = count == '0;
   assign full = count == (AW+1)'(FIFO_DEPTH);
   assign wb.wb_stall = wb.wb_cyc & wb.wb_stb & wb.wb_we & (wb.wb_addr == '0) & full;
   assign accept = wb.wb_cyc & wb.wb_stb & ~wb.wb_stall;
   assign push = accept & wb.wb_we & (wb.wb_addr == '0);
   assign rdata = wb.wb_addr == ADDR_WIDTH'(1) ? MEM_WIDTH'({4'(count), 1'b0, empty, full, state != IDLE}) :
                  wb.wb_addr == ADDR_WIDTH'(2) ? MEM_WIDTH'(baud_div) : '0;
   assign last = cnt == div - 16'd1;
   // A pop reloads the shifter and latches the divisor, so BAUDDIV changes only land at frame start.
   always_comb begin
      state_n = state;
      cnt_n = last ? '0 : cnt + 16'd1;
      div_n = div;
      shreg_n = shreg;
      bit_idx_n = bit_idx;
      pop = ~empty & (state == IDLE | (state == STOP & last));
      case (state)
         START: state_n = last ? DATA : START;
         DATA: if (last) begin
            shreg_n = shreg >> 1;
            bit_idx_n = bit_idx + 3'd1;
            state_n = bit_idx == 3'd7 ? STOP : DATA;
         end
         STOP: state_n = last ? IDLE : STOP;
         default: ;
      endcase
      if (pop) begin
         state_n = START;
         shreg_n = mem[rd_ptr[AW-1:0]];
         div_n = baud_div == '0 ? 16'd1 : baud_div;
         cnt_n = '0;
         bit_idx_n = '0;
      end
      tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : 1'b1;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wb.wb_ack <= 1'b0;
         wb.wb_data_out <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         baud_div <= 16'(BAUD_DIV_RESET);
         state <= IDLE;
         div <= 16'd1;
         cnt <= '0;
         shreg <= '0;
         bit_idx <= '0;
         uart_tx <= 1'b1;
      end else begin
         wb.wb_ack <= accept;
         wb.wb_data_out <= accept & ~wb.wb_we ? rdata : '0;
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         baud_div <= accept & wb.wb_we & (wb.wb_addr == ADDR_WIDTH'(2)) ? wb.wb_data_in[15:0] : baud_div;
         state <= state_n;
         div <= div_n;
         cnt <= cnt_n;
         shreg <= shreg_n;
         bit_idx <= bit_idx_n;
         uart_tx <= tx_n;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wb.wb_data_in[7:0];
   end
endmodule

// File: tb/tb_leiwand_rv32_wb_uart_tx.sv
// tb_leiwand_rv32_wb_uart_tx: directed vectors and serial-frame checks for the Wishbone UART transmitter
module tb_leiwand_rv32_wb_uart_tx;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic uart_tx;
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int nz_bad = 0;
   int ack_in_reset = 0;
   int ack_gap = 0;
   leiwand_rv32_wb_uart_tx_if bif ();
   leiwand_rv32_wb_uart_tx dut (.clk(clk), .reset(reset), .wb(bif.slave), .uart_tx(uart_tx));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (cyc > 1 && bif.wb_ack !== 1'b1 && bif.wb_data_out !== '0) nz_bad++;
      if (reset && bif.wb_ack === 1'b1) ack_in_reset++;
   end

   // Frame monitor: latches mon_div at the start bit and checks every cycle of the frame.
   logic [7:0] rx_q[$];
   int rx_start_q[$];
   bit rx_ok_q[$];
   int mon_div = 16;
   bit mon_en = 1'b1;
   int m_d, m_s;
   logic [9:0] m_bv;
   bit m_ok;
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && !reset && uart_tx === 1'b0) begin
            m_d = mon_div;
            m_s = cyc;
            m_bv = '0;
            m_ok = 1'b1;
            for (int k = 0; k < 10 * m_d; k++) begin
               if (k > 0) @(negedge clk);
               if (k % m_d == 0) m_bv[k / m_d] = uart_tx;
               else if (uart_tx !== m_bv[k / m_d]) m_ok = 1'b0;
            end
            if (m_bv[0] !== 1'b0 || m_bv[9] !== 1'b1) m_ok = 1'b0;
            rx_q.push_back(m_bv[8:1]);
            rx_start_q.push_back(m_s);
            rx_ok_q.push_back(m_ok);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: timed out", nm);
   endtask

   task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d,
                      output logic [31:0] r, output int acc);
      int n = 0;
      @(negedge clk);
      bif.wb_cyc = 1'b1;
      bif.wb_stb = 1'b1;
      bif.wb_we = we;
      bif.wb_addr = a;
      bif.wb_data_in = d;
      #1;
      while (bif.wb_stall && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (bif.wb_stall) fail_now("bus_stall");
      acc = cyc;
      @(posedge clk);
      #1;
      chk("bus_ack", 32'(bif.wb_ack), 32'd1);
      r = bif.wb_data_out;
      bif.wb_cyc = 1'b0;
      bif.wb_stb = 1'b0;
      bif.wb_we = 1'b0;
      @(posedge clk);
      #1;
      chk("bus_ack_single", 32'(bif.wb_ack), 32'd0);
   endtask

   task automatic get_frame(input string nm, input logic [7:0] exp, output int st);
      int n = 0;
      st = -1;
      while (rx_q.size() == 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (rx_q.size() == 0) fail_now(nm);
      else begin
         chk({nm, "_byte"}, 32'(rx_q.pop_front()), 32'(exp));
         chk({nm, "_shape"}, 32'(rx_ok_q.pop_front()), 32'd1);
         st = rx_start_q.pop_front();
      end
   endtask

   task automatic wait_start();
      int n = 0;
      while (uart_tx !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (uart_tx !== 1'b0) fail_now("wait_start");
   endtask

   // Back-to-back STATUS reads; returns the first cycle in which busy was clear.
   task automatic poll_idle(output int idle_at);
      int n = 0;
      idle_at = -1;
      @(negedge clk);
      bif.wb_cyc = 1'b1;
      bif.wb_stb = 1'b1;
      bif.wb_we = 1'b0;
      bif.wb_addr = 2'd1;
      @(negedge clk);
      while (n < 5000) begin
         if (bif.wb_ack !== 1'b1) ack_gap++;
         else if (bif.wb_data_out[0] == 1'b0) begin
            idle_at = cyc - 1;
            break;
         end
         @(negedge clk);
         n++;
      end
      bif.wb_cyc = 1'b0;
      bif.wb_stb = 1'b0;
      if (idle_at < 0) fail_now("poll_idle");
   endtask

   typedef struct {
      logic we;
      logic [1:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[10];
   logic [31:0] r;
   int a, s1, s2, idle, low_n;
   int acc_b[6], stall_n[6], st_b[6];

   initial begin
      vt[0] = '{1'b0, 2'd1, 32'h0, 32'h4};
      vt[1] = '{1'b0, 2'd2, 32'h0, 32'd16};
      vt[2] = '{1'b1, 2'd2, 32'hFFFF_1234, 32'h0};
      vt[3] = '{1'b0, 2'd2, 32'h0, 32'h1234};
      vt[4] = '{1'b1, 2'd3, 32'hDEAD_BEEF, 32'h0};
      vt[5] = '{1'b0, 2'd3, 32'h0, 32'h0};
      vt[6] = '{1'b0, 2'd0, 32'h0, 32'h0};
      vt[7] = '{1'b0, 2'd1, 32'h0, 32'h4};
      vt[8] = '{1'b1, 2'd2, 32'd4, 32'h0};
      vt[9] = '{1'b0, 2'd2, 32'h0, 32'd4};
      bif.wb_cyc = 1'b0;
      bif.wb_stb = 1'b0;
      bif.wb_we = 1'b0;
      bif.wb_addr = '0;
      bif.wb_data_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_uart_tx", 32'(uart_tx), 32'd1);
      chk("rst_ack", 32'(bif.wb_ack), 32'd0);
      chk("rst_dout", bif.wb_data_out, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         bus(vt[i].we, vt[i].addr, vt[i].wdata, r, a);
         if (!vt[i].we) chk($sformatf("vec%0d", i), r, vt[i].exp);
      end

      // Single byte at div 4: start bit two cycles after the accept, busy for 40 cycles.
      mon_div = 4;
      bus(1'b1, 2'd0, 32'h1234_56A5, r, a);
      wait_start();
      poll_idle(idle);
      get_frame("single", 8'hA5, s1);
      chk("single_start", 32'(s1), 32'(a + 2));
      chk("single_busy", 32'(idle - s1), 32'd40);

      // Divisor written mid-frame applies to the next frame only.
      bus(1'b1, 2'd0, 32'h3C, r, a);
      bus(1'b1, 2'd0, 32'h96, r, a);
      bus(1'b1, 2'd2, 32'd8, r, a);
      mon_div = 8;
      poll_idle(idle);
      get_frame("bd_f1", 8'h3C, s1);
      get_frame("bd_f2", 8'h96, s2);
      chk("bd_f1_len", 32'(s2 - s1), 32'd40);
      chk("bd_f2_len", 32'(idle - s2), 32'd80);
      bus(1'b1, 2'd2, 32'd0, r, a);
      mon_div = 1;
      bus(1'b1, 2'd0, 32'h5A, r, a);
      wait_start();
      poll_idle(idle);
      get_frame("bd0", 8'h5A, s1);
      chk("bd0_len", 32'(idle - s1), 32'd10);

      // Read path: two bytes queued behind a frame in flight.
      bus(1'b1, 2'd2, 32'd16, r, a);
      mon_div = 16;
      bus(1'b1, 2'd0, 32'h11, r, a);
      bus(1'b1, 2'd0, 32'h22, r, a);
      bus(1'b1, 2'd0, 32'h33, r, a);
      bus(1'b0, 2'd1, 32'h0, r, a);
      chk("status_busy_q2", r, 32'h21);
      get_frame("rp1", 8'h11, s1);
      get_frame("rp2", 8'h22, s1);
      get_frame("rp3", 8'h33, s1);

      // Burst of six writes: the sixth stalls until the first STOP pops.
      @(negedge clk);
      bif.wb_cyc = 1'b1;
      bif.wb_stb = 1'b1;
      bif.wb_we = 1'b1;
      bif.wb_addr = 2'd0;
      for (int i = 0; i < 6; i++) begin
         int n;
         bif.wb_data_in = 32'(i + 1);
         #1;
         n = 0;
         while (bif.wb_stall && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
         end
         stall_n[i] = n;
         acc_b[i] = cyc;
         @(posedge clk);
         #1;
         chk("burst_ack", 32'(bif.wb_ack), 32'd1);
      end
      bif.wb_cyc = 1'b0;
      bif.wb_stb = 1'b0;
      bif.wb_we = 1'b0;
      for (int i = 0; i < 6; i++) get_frame($sformatf("burst%0d", i), 8'(i + 1), st_b[i]);
      chk("burst_b2b", 32'(acc_b[4] - acc_b[0]), 32'd4);
      chk("burst_no_early_stall", 32'(stall_n[0] + stall_n[1] + stall_n[2] + stall_n[3] + stall_n[4]), 32'd0);
      chk("burst_stall_len", 32'(stall_n[5]), 32'd157);
      chk("burst_first_start", 32'(st_b[0]), 32'(acc_b[0] + 2));
      chk("burst_sixth_accept", 32'(acc_b[5]), 32'(st_b[0] + 160));
      for (int i = 1; i < 6; i++) chk($sformatf("burst_gap%0d", i), 32'(st_b[i] - st_b[i-1]), 32'd160);

      // Reset in the middle of a frame with bytes still queued.
      mon_en = 1'b0;
      bus(1'b1, 2'd2, 32'd5, r, a);
      bus(1'b1, 2'd0, 32'h77, r, a);
      bus(1'b1, 2'd0, 32'h88, r, a);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      bif.wb_cyc = 1'b1;
      bif.wb_stb = 1'b1;
      bif.wb_we = 1'b0;
      bif.wb_addr = 2'd1;
      repeat (2) @(negedge clk);
      chk("midrst_uart_tx", 32'(uart_tx), 32'd1);
      chk("midrst_ack", 32'(bif.wb_ack), 32'd0);
      reset = 1'b0;
      bif.wb_cyc = 1'b0;
      bif.wb_stb = 1'b0;
      bus(1'b0, 2'd1, 32'h0, r, a);
      chk("midrst_status", r, 32'h4);
      bus(1'b0, 2'd2, 32'h0, r, a);
      chk("midrst_bauddiv", r, 32'd16);
      low_n = 0;
      repeat (200) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) low_n++;
      end
      chk("midrst_line_idle", 32'(low_n), 32'd0);
      mon_en = 1'b1;

      chk("dout_zero_nonack", 32'(nz_bad), 32'd0);
      chk("no_ack_in_reset", 32'(ack_in_reset), 32'd0);
      chk("b2b_ack_gaps", 32'(ack_gap), 32'd0);
      chk("no_extra_frames", 32'(rx_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
